prog_loader: RTL

Program loader and run controller that sits directly upstream of the single-cycle core's `top_level` and its instruction ROM. It accepts a byte stream over a valid/ready handshake and unpacks it into 9-bit instructions written sequentially into instruction memory. It holds the core in reset during loading, releases it, counts execution cycles until the core raises `done`, and reports finish, timeout or format errors.

---
 rtl/loader_pkg.sv | 16 +
 rtl/byte_unpacker.sv | 17 +
 rtl/prog_loader.sv | 94 +++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding, error codes and instruction width for the program loader
package loader_pkg;
    localparam int INST_W = 9;
    typedef enum logic [3:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_INST_LO, S_INST_HI, S_WRITE, S_RUN, S_FINISHED, S_ERROR
    } ldr_state_t;
    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_ZERO_LEN = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    function automatic logic can_start(ldr_state_t s);
        return s inside {S_IDLE, S_FINISHED, S_ERROR};
    endfunction
    function automatic logic takes_bytes(ldr_state_t s);
        return s inside {S_LEN_LO, S_LEN_HI, S_INST_LO, S_INST_HI};
    endfunction
endpackage

// File: rtl/byte_unpacker.sv
// byte_unpacker: assembles a low byte and bit 0 of a high byte into one instruction word
module byte_unpacker
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              lo_we,
    input  logic              hi_we,
    input  logic [7:0]        data,
    output logic [INST_W-1:0] word
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) word <= '0;
        else if (lo_we) word[7:0] <= data;
        else if (hi_we) word[INST_W-1] <= data[0];
    end
endmodule

// File: rtl/prog_loader.sv
// prog_loader: streams a program into instruction memory, then runs the core until done or timeout
module prog_loader
    import loader_pkg::*;
#(
    parameter int          ADDR_W     = 12,
    parameter logic [31:0] MAX_CYCLES = 32'd1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [INST_W-1:0] imem_wdata,
    output logic              core_reset,
    input  logic              core_done,
    output logic              busy,
    output logic              finished,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [31:0]       cycle_count
);
    ldr_state_t state, state_n;
    logic [ADDR_W-1:0] len, len_asm;
    logic acc, go, last, timeout;

    assign in_ready   = takes_bytes(state);
    assign imem_we    = state == S_WRITE;
    assign core_reset = state != S_RUN;
    assign busy       = !can_start(state);
    assign finished   = state == S_FINISHED;
    assign error      = state == S_ERROR;
    assign acc        = in_valid & in_ready;
    assign go         = start & can_start(state);
    assign len_asm    = {in_data[ADDR_W-9:0], len[7:0]};
    assign last       = (imem_addr + ADDR_W'(1)) == len;
    assign timeout    = cycle_count == MAX_CYCLES - 32'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE, S_FINISHED, S_ERROR: state_n = go ? S_LEN_LO : state;
            S_LEN_LO:  state_n = acc ? S_LEN_HI : state;
            S_LEN_HI:  state_n = !acc ? state : (len_asm == '0 ? S_ERROR : S_INST_LO);
            S_INST_LO: state_n = acc ? S_INST_HI : state;
            S_INST_HI: state_n = acc ? S_WRITE : state;
            S_WRITE:   state_n = last ? S_RUN : S_INST_LO;
            S_RUN:     state_n = core_done ? S_FINISHED : (timeout ? S_ERROR : S_RUN);
            default:   state_n = S_IDLE;
        endcase
    end

    // a length that wraps to zero is indistinguishable from an explicit zero and is rejected the same way
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len         <= '0;
            imem_addr   <= '0;
            cycle_count <= '0;
            err_code    <= ERR_NONE;
        end else begin
            if (go) begin
                cycle_count <= '0;
                imem_addr   <= '0;
                err_code    <= ERR_NONE;
            end
            if (acc && state == S_LEN_LO) len[7:0] <= in_data;
            if (acc && state == S_LEN_HI) begin
                len <= len_asm;
                if (len_asm == '0) err_code <= ERR_ZERO_LEN;
            end
            if (state == S_WRITE && !last) imem_addr <= imem_addr + ADDR_W'(1);
            if (state == S_RUN) begin
                cycle_count <= cycle_count + 32'd1;
                if (!core_done && timeout) err_code <= ERR_TIMEOUT;
            end
        end
    end

    byte_unpacker u_unpack (
        .clk  (clk),
        .reset(reset),
        .lo_we(acc && state == S_INST_LO),
        .hi_we(acc && state == S_INST_HI),
        .data (in_data),
        .word (imem_wdata)
    );
endmodule
